// File: rtl/sd_data_serial_card_if.sv
`default_nettype none
// ============================================================================
// Interface : sd_data_serial_card_if
// Purpose   : DAT bus, control and word-FIFO signals of the SD card data
//             serialiser. The host/bench side is master; the card is slave.
// Revision  : 1.0 - initial release
// ============================================================================
interface sd_data_serial_card_if;
  logic [3:0]  DAT_dat_i;
  logic [3:0]  DAT_dat_o;
  logic        DAT_oe_o;
  logic        start_rx;
  logic        start_tx;
  logic        abort;
  logic [31:0] tx_data;
  logic        tx_rd;
  logic [31:0] rx_data;
  logic        rx_we;
  logic        busy;
  logic        done;
  logic        crc_ok;

  modport master (
    output DAT_dat_i, start_rx, start_tx, abort, tx_data,
    input  DAT_dat_o, DAT_oe_o, tx_rd, rx_data, rx_we, busy, done, crc_ok
  );

  modport slave (
    input  DAT_dat_i, start_rx, start_tx, abort, tx_data,
    output DAT_dat_o, DAT_oe_o, tx_rd, rx_data, rx_we, busy, done, crc_ok
  );
endinterface
`default_nettype wire

// File: rtl/sd_data_serial_card.sv
`default_nettype none
// ============================================================================
// Module    : sd_data_serial_card
// Purpose   : Card-side 4-bit SD DAT serialiser. Receives host write blocks
//             (with per-line CRC16 check, status token and busy signalling)
//             and transmits read blocks with per-line CRC16.
// Revision  : 1.0 - initial release
// ============================================================================
module sd_data_serial_card #(
  parameter int BLOCK_NIBBLES = 1024,
  parameter int BUSY_CYCLES   = 8
) (
  input wire                   sd_clk,
  input wire                   rst,
  sd_data_serial_card_if.slave bus
);
  localparam int CNT_MAX = (BLOCK_NIBBLES + 18 > BUSY_CYCLES) ? BLOCK_NIBBLES + 18 : BUSY_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_DAT_LAST = CW'(BLOCK_NIBBLES - 1);
  localparam logic [CW-1:0] C_CRC_LAST = CW'(15);
  localparam logic [CW-1:0] C_TOK_LAST = CW'(4);
  localparam logic [CW-1:0] C_BSY_LAST = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] C_TXD_LAST = CW'(BLOCK_NIBBLES);
  localparam logic [CW-1:0] C_TXC_LAST = CW'(BLOCK_NIBBLES + 16);
  localparam logic [CW-1:0] C_TX_LAST  = CW'(BLOCK_NIBBLES + 17);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] RX_WAIT  = 4'd1;
  localparam logic [3:0] RX_DAT   = 4'd2;
  localparam logic [3:0] RX_CRC   = 4'd3;
  localparam logic [3:0] RX_END   = 4'd4;
  localparam logic [3:0] ST_GAP   = 4'd5;
  localparam logic [3:0] ST_TOKEN = 4'd6;
  localparam logic [3:0] WR_BUSY  = 4'd7;
  localparam logic [3:0] WR_REL   = 4'd8;
  localparam logic [3:0] TX_NAC   = 4'd9;
  localparam logic [3:0] TX_DAT   = 4'd10;

  logic [3:0]    state, state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nib_idx;
  logic [31:0]   rx_sr, tx_sr, rx_data;
  logic [3:0]    crc_msb;
  logic          crc_err, crc_ok_rx, rx_we, done, crc_ok;
  logic          tx_data_ph, tx_crc_ph, tx_load;
  logic          oe, token_bit;
  logic [3:0]    dat;

  // Serial CRC16-CCITT step (x^16+x^12+x^5+1), one bit per call
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ (((c[15] ^ d) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  // Read-path phase decode; the word FIFO is popped at the start nibble and
  // on the last nibble of every word except the final one
  assign nib_idx    = cnt - C_ONE;
  assign tx_data_ph = (state == TX_DAT) && (cnt >= C_ONE) && (cnt <= C_TXD_LAST);
  assign tx_crc_ph  = (state == TX_DAT) && (cnt > C_TXD_LAST) && (cnt <= C_TXC_LAST);
  assign tx_load    = (state == TX_DAT) && ((cnt == '0) ||
                      (tx_data_ph && (nib_idx[2:0] == 3'd7) && (nib_idx != C_DAT_LAST)));

  // State register
  always_ff @(posedge sd_clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode; abort overrides everything, starts only count in IDLE
  always_comb begin
    state_next = state;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (bus.start_rx) state_next = RX_WAIT;
                  else if (bus.start_tx) state_next = TX_NAC;
        RX_WAIT:  if (!bus.DAT_dat_i[0]) state_next = RX_DAT;
        RX_DAT:   if (cnt == C_DAT_LAST) state_next = RX_CRC;
        RX_CRC:   if (cnt == C_CRC_LAST) state_next = RX_END;
        RX_END:   state_next = ST_GAP;
        ST_GAP:   if (cnt == C_ONE) state_next = ST_TOKEN;
        ST_TOKEN: if (cnt == C_TOK_LAST) state_next = WR_BUSY;
        WR_BUSY:  if (cnt == C_BSY_LAST) state_next = WR_REL;
        WR_REL:   state_next = IDLE;
        TX_NAC:   if (cnt == C_ONE) state_next = TX_DAT;
        TX_DAT:   if (cnt == C_TX_LAST) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Bus drive, token bit sequence 0,s2,s1,s0,1 and FIFO pop strobe
  always_comb begin
    oe        = 1'b0;
    dat       = 4'hF;
    token_bit = 1'b1;
    case (cnt[2:0])
      3'd0:    token_bit = 1'b0;
      3'd1:    token_bit = !crc_ok_rx;
      3'd2:    token_bit = crc_ok_rx;
      3'd3:    token_bit = !crc_ok_rx;
      default: token_bit = 1'b1;
    endcase
    case (state)
      ST_TOKEN: begin oe = 1'b1; dat = {3'b111, token_bit}; end
      WR_BUSY:  begin oe = 1'b1; dat = 4'hE; end
      WR_REL:   begin oe = 1'b1; dat = 4'hF; end
      TX_DAT: begin
        oe = 1'b1;
        if (cnt == '0)      dat = 4'h0;
        else if (tx_data_ph) dat = tx_sr[3:0];
        else if (tx_crc_ph)  dat = crc_msb;
        else                 dat = 4'hF;
      end
      default: ;
    endcase
  end

  assign bus.DAT_oe_o  = oe;
  assign bus.DAT_dat_o = dat;
  assign bus.tx_rd     = tx_load && !bus.abort && rst;
  assign bus.busy      = (state != IDLE);
  assign bus.rx_data   = rx_data;
  assign bus.rx_we     = rx_we;
  assign bus.done      = done;
  assign bus.crc_ok    = crc_ok;

  // Phase counter: restarts on every state change, idle in IDLE and RX_WAIT
  always_ff @(posedge sd_clk) begin
    if (!rst || state == IDLE || state == RX_WAIT || state_next != state) cnt <= '0;
    else cnt <= cnt + C_ONE;
  end

  // One independent CRC per DAT line; in CRC phases the register shifts out MSB first
  for (genvar i = 0; i < 4; i++) begin : g_crc
    logic [15:0] crc_q;
    always_ff @(posedge sd_clk) begin
      if (!rst || bus.abort || state == IDLE) crc_q <= '0;
      else if (state == RX_DAT)               crc_q <= crc_step(crc_q, bus.DAT_dat_i[i]);
      else if (tx_data_ph)                    crc_q <= crc_step(crc_q, tx_sr[i]);
      else if (state == RX_CRC || tx_crc_ph)  crc_q <= {crc_q[14:0], 1'b0};
    end
    assign crc_msb[i] = crc_q[15];
  end

  // Word assembly/serialisation, receive status and completion strobes
  always_ff @(posedge sd_clk) begin
    if (!rst) begin
      rx_sr <= '0; rx_data <= '0; rx_we <= 1'b0; tx_sr <= '0;
      crc_err <= 1'b0; crc_ok_rx <= 1'b0; done <= 1'b0; crc_ok <= 1'b0;
    end else begin
      rx_we <= 1'b0;
      done  <= 1'b0;
      if (bus.abort) begin
        crc_ok <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            crc_err <= 1'b0;
            if (bus.start_rx || bus.start_tx) crc_ok <= 1'b0;
          end
          RX_DAT: begin
            rx_sr <= {bus.DAT_dat_i, rx_sr[31:4]};
            if (cnt[2:0] == 3'd7) begin
              rx_we   <= 1'b1;
              rx_data <= {bus.DAT_dat_i, rx_sr[31:4]};
            end
          end
          RX_CRC:  if (bus.DAT_dat_i != crc_msb) crc_err <= 1'b1;
          RX_END:  crc_ok_rx <= !crc_err && (bus.DAT_dat_i == 4'hF);
          WR_REL:  begin done <= 1'b1; crc_ok <= crc_ok_rx; end
          TX_DAT: begin
            if (tx_load)         tx_sr <= bus.tx_data;
            else if (tx_data_ph) tx_sr <= {4'h0, tx_sr[31:4]};
            if (cnt == C_TX_LAST) begin done <= 1'b1; crc_ok <= 1'b1; end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sd_data_serial_card.sv
`default_nettype none
// ============================================================================
// Module    : tb_sd_data_serial_card
// Purpose   : Self-checking bench for sd_data_serial_card (16-nibble blocks)
// Revision  : 1.0 - initial release
// ============================================================================
module tb_sd_data_serial_card;
  localparam int BN = 16;
  localparam int BC = 8;
  localparam int NW = BN / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_data_serial_card_if bus();

  sd_data_serial_card #(.BLOCK_NIBBLES(BN), .BUSY_CYCLES(BC)) dut (
    .sd_clk(clk),
    .rst   (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // First-word-fall-through source for read blocks
  logic [31:0] tx_mem [64];
  logic [5:0]  rd_ptr = '0;
  assign bus.tx_data = tx_mem[rd_ptr];
  always @(posedge clk) if (bus.tx_rd) rd_ptr <= rd_ptr + 6'd1;

  // Strobe monitors
  int rx_we_cnt = 0, tx_rd_cnt = 0, done_cnt = 0;
  logic [31:0] rx_q[$];
  always @(negedge clk) begin
    if (bus.rx_we) begin rx_we_cnt++; rx_q.push_back(bus.rx_data); end
    if (bus.tx_rd) tx_rd_cnt++;
    if (bus.done)  done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC as remainder of M(x)*x^16 divided by G(x), computed by long division
  function automatic logic [15:0] ref_crc(input logic [31:0] w [NW], input int line);
    logic [BN+15:0] a;
    a = '0;
    for (int n = 0; n < BN; n++) a[BN+15-n] = w[n/8][4*(n%8)+line];
    for (int i = BN + 15; i >= 16; i--)
      if (a[i]) a[i-:17] = a[i-:17] ^ 17'h11021;
    return a[15:0];
  endfunction

  task automatic do_write(input logic [31:0] w0, input logic [31:0] w1, input int flip_line,
                          input logic [3:0] end_nib, input int abort_at, input string tag);
    logic [31:0] w [NW];
    logic [15:0] c [4];
    logic [3:0]  nib;
    logic [4:0]  tok;
    logic        ok;
    int d0, fb;
    w[0] = w0; w[1] = w1;
    for (int l = 0; l < 4; l++) c[l] = ref_crc(w, l);
    ok  = (flip_line < 0) && (end_nib == 4'hF);
    tok = ok ? 5'b00101 : 5'b01011;
    fb  = $urandom_range(0, 15);
    rx_q.delete();
    d0 = done_cnt;
    bus.DAT_dat_i = 4'hF;
    bus.start_rx = 1'b1; tick(); bus.start_rx = 1'b0;
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    repeat ($urandom_range(0, 3)) tick();
    bus.DAT_dat_i = 4'h0; tick();
    for (int n = 0; n < BN; n++) begin
      bus.DAT_dat_i = w[n/8][4*(n%8)+:4];
      if (n == abort_at) bus.abort = 1'b1;
      tick();
      if (n == abort_at) begin
        bus.abort = 1'b0; bus.DAT_dat_i = 4'hF;
        check({tag, " abort oe"}, 32'(bus.DAT_oe_o), 32'd0);
        check({tag, " abort busy"}, 32'(bus.busy), 32'd0);
        check({tag, " abort crc_ok"}, 32'(bus.crc_ok), 32'd0);
        repeat (4) tick();
        check({tag, " abort words"}, 32'(rx_q.size()), 32'(n / 8));
        check({tag, " abort no done"}, 32'(done_cnt), 32'(d0));
        return;
      end
    end
    check({tag, " last rx_we"}, 32'(bus.rx_we), 32'd1);
    check({tag, " last rx_data"}, bus.rx_data, w[NW-1]);
    for (int j = 0; j < 16; j++) begin
      for (int l = 0; l < 4; l++) nib[l] = c[l][15-j];
      if (flip_line >= 0 && j == fb) nib[flip_line] = ~nib[flip_line];
      bus.DAT_dat_i = nib; tick();
    end
    bus.DAT_dat_i = end_nib; tick();
    bus.DAT_dat_i = 4'hF;
    check({tag, " words"}, 32'(rx_q.size()), 32'(NW));
    for (int k = 0; k < NW && k < rx_q.size(); k++)
      check($sformatf("%s word%0d", tag, k), rx_q[k], w[k]);
    check({tag, " gap0 oe"}, 32'(bus.DAT_oe_o), 32'd0); tick();
    check({tag, " gap1 oe"}, 32'(bus.DAT_oe_o), 32'd0); tick();
    for (int t = 0; t < 5; t++) begin
      check($sformatf("%s token oe%0d", tag, t), 32'(bus.DAT_oe_o), 32'd1);
      check($sformatf("%s token%0d", tag, t), 32'(bus.DAT_dat_o), 32'({3'b111, tok[4-t]}));
      tick();
    end
    for (int b = 0; b < BC; b++) begin
      check($sformatf("%s busy%0d", tag, b), 32'({bus.DAT_oe_o, bus.DAT_dat_o}), 32'h1E);
      tick();
    end
    check({tag, " release"}, 32'({bus.DAT_oe_o, bus.DAT_dat_o}), 32'h1F); tick();
    check({tag, " end oe"}, 32'(bus.DAT_oe_o), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " crc_ok"}, 32'(bus.crc_ok), 32'(ok));
    check({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    tick();
    check({tag, " done pulse"}, 32'(bus.done), 32'd0);
    check({tag, " crc_ok hold"}, 32'(bus.crc_ok), 32'(ok));
  endtask

  task automatic do_read(input logic [31:0] w0, input logic [31:0] w1, input int rst_at,
                         input string tag);
    logic [31:0] w [NW];
    logic [15:0] c [4];
    logic [3:0]  s [BN+18];
    logic        exp_rd;
    int d0, r0;
    w[0] = w0; w[1] = w1;
    for (int l = 0; l < 4; l++) c[l] = ref_crc(w, l);
    s[0] = 4'h0;
    for (int n = 0; n < BN; n++) s[1+n] = w[n/8][4*(n%8)+:4];
    for (int j = 0; j < 16; j++)
      for (int l = 0; l < 4; l++) s[BN+1+j][l] = c[l][15-j];
    s[BN+17] = 4'hF;
    tx_mem[rd_ptr] = w0;
    tx_mem[rd_ptr + 6'd1] = w1;
    d0 = done_cnt; r0 = tx_rd_cnt;
    bus.start_tx = 1'b1; tick(); bus.start_tx = 1'b0;
    check({tag, " nac0 oe"}, 32'(bus.DAT_oe_o), 32'd0);
    check({tag, " busy"}, 32'(bus.busy), 32'd1); tick();
    check({tag, " nac1 oe"}, 32'(bus.DAT_oe_o), 32'd0); tick();
    for (int k = 0; k < BN + 18; k++) begin
      if (k == rst_at) begin
        rst = 1'b0; tick(); rst = 1'b1;
        check({tag, " rst oe"}, 32'(bus.DAT_oe_o), 32'd0);
        check({tag, " rst dat"}, 32'(bus.DAT_dat_o), 32'hF);
        check({tag, " rst busy"}, 32'(bus.busy), 32'd0);
        check({tag, " rst crc_ok"}, 32'(bus.crc_ok), 32'd0);
        check({tag, " rst rx_data"}, bus.rx_data, 32'd0);
        repeat (3) tick();
        check({tag, " rst no done"}, 32'(done_cnt), 32'(d0));
        return;
      end
      exp_rd = (k == 0) || (k >= 1 && k <= BN && ((k - 1) % 8) == 7 && (k - 1) != BN - 1);
      check($sformatf("%s oe%0d", tag, k), 32'(bus.DAT_oe_o), 32'd1);
      check($sformatf("%s dat%0d", tag, k), 32'(bus.DAT_dat_o), 32'(s[k]));
      check($sformatf("%s tx_rd%0d", tag, k), 32'(bus.tx_rd), 32'(exp_rd));
      tick();
    end
    check({tag, " end oe"}, 32'(bus.DAT_oe_o), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " crc_ok"}, 32'(bus.crc_ok), 32'd1);
    tick();
    check({tag, " tx_rd total"}, 32'(tx_rd_cnt - r0), 32'(NW));
    check({tag, " done once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    bus.DAT_dat_i = 4'hF; bus.start_rx = 1'b0; bus.start_tx = 1'b0; bus.abort = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    check("reset oe", 32'(bus.DAT_oe_o), 32'd0);
    check("reset dat", 32'(bus.DAT_dat_o), 32'hF);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset crc_ok", 32'(bus.crc_ok), 32'd0);
    check("reset rx_we", 32'(bus.rx_we), 32'd0);
    check("reset tx_rd", 32'(bus.tx_rd), 32'd0);
    check("reset rx_data", bus.rx_data, 32'd0);
    rst = 1'b1; tick();

    do_write(32'h0, 32'h0, -1, 4'hF, -1, "wr_zero");
    do_write(32'h0, 32'h0, 2, 4'hF, -1, "wr_crc_dat2");
    do_write($urandom(), $urandom(), -1, 4'hF, -1, "wr_rand");
    do_write($urandom(), $urandom(), -1, 4'h7, -1, "wr_bad_end");
    do_write($urandom(), $urandom(), $urandom_range(0, 3), 4'hF, -1, "wr_rand_crcerr");
    do_read(32'h87654321, 32'hFEDCBA98, -1, "rd_fixed");
    do_read($urandom(), $urandom(), -1, "rd_rand");

    // Simultaneous starts: receive wins, so the card never drives the bus
    d0 = done_cnt;
    bus.start_rx = 1'b1; bus.start_tx = 1'b1; tick();
    bus.start_rx = 1'b0; bus.start_tx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("both busy%0d", i), 32'(bus.busy), 32'd1);
      check($sformatf("both oe%0d", i), 32'(bus.DAT_oe_o), 32'd0);
      bus.start_tx = (i == 1); tick(); bus.start_tx = 1'b0;
    end
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    check("both abort busy", 32'(bus.busy), 32'd0);
    check("both no done", 32'(done_cnt), 32'(d0));

    do_write($urandom(), $urandom(), -1, 4'hF, $urandom_range(1, BN - 2), "wr_abort");
    do_write($urandom(), $urandom(), -1, 4'hF, -1, "wr_after_abort");
    do_read($urandom(), $urandom(), $urandom_range(1, BN + 16), "rd_rst");
    do_write($urandom(), $urandom(), -1, 4'hF, -1, "wr_after_rst");
    do_read($urandom(), $urandom(), -1, "rd_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sd_data_serial_card.md
SD_DATA_SERIAL_CARD -- requirements
Module: sd_data_serial_card

Interface
REQ-001 Parameter BLOCK_NIBBLES, default 1024, is the data nibbles per block per 4-bit bus; a multiple of 8, minimum 8.
REQ-002 Parameter BUSY_CYCLES, default 8, is the number of cycles DAT0 is held low after a write status token; minimum 1.
REQ-003 sd_clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  is the reset: synchronous, active-low.
REQ-005 DAT_dat_i  input  4  carries the DAT lines driven by the host.
REQ-006 DAT_dat_o  output  4  carries the DAT values driven by the card.
REQ-007 DAT_oe_o  output  1  enables the DAT_dat_o drivers.
REQ-008 start_rx  input  1  is a one-cycle pulse that arms reception of a host write block.
REQ-009 start_tx  input  1  is a one-cycle pulse that starts transmission of a read block to the host.
REQ-010 abort  input  1  forces an immediate return to IDLE.
REQ-011 tx_data  input  32  is the next read word, first-word-fall-through.
REQ-012 tx_rd  output  1  pulses for one cycle when tx_data is consumed.
REQ-013 rx_data  output  32  carries the assembled received word.
REQ-014 rx_we  output  1  is the one-cycle write strobe for rx_data.
REQ-015 busy  output  1  is high whenever the state is not IDLE.
REQ-016 done  output  1  is a one-cycle pulse when a transfer completes normally.
REQ-017 crc_ok  output  1  is the result of the last transfer, valid from done until the next start.

Function
REQ-018 States are IDLE, RX_WAIT, RX_DAT, RX_CRC, RX_END, ST_GAP, ST_TOKEN, WR_BUSY, WR_REL, TX_NAC and TX_DAT.
REQ-019 Nibble order: word bits [3:0] go first on the bus, [31:28] last; DAT[i] carries bit i of each nibble.
REQ-020 CRC: an independent CRC16 runs per line, polynomial x^16+x^12+x^5+1, initial value 0, transmitted MSB first; it covers data nibbles only.
REQ-021 IDLE: DAT_oe_o=0, DAT_dat_o=4'hF; start_rx moves to RX_WAIT, else start_tx moves to TX_NAC; if both are asserted, start_rx wins.
REQ-022 RX_WAIT: in the first cycle with DAT_dat_i[0]==0 (the start bit), the next state is RX_DAT.
REQ-023 RX_DAT: sample BLOCK_NIBBLES cycles; after every 8th nibble assert rx_we for one cycle with rx_data holding the full word; the last rx_we coincides with the first RX_CRC cycle.
REQ-024 RX_CRC: sample 16 cycles and compare each line against its computed CRC.
REQ-025 RX_END: sample 1 cycle; the end bit is valid when DAT_dat_i==4'hF.
REQ-026 Receive status: crc_ok_rx = (all four CRCs match) AND (end bit valid).
REQ-027 ST_GAP: 2 cycles with DAT_oe_o=0.
REQ-028 ST_TOKEN: 5 cycles with DAT_oe_o=1; DAT_dat_o[3:1]=3'b111; DAT_dat_o[0] carries 0, s2, s1, s0, 1.
REQ-029 Token status: s2..s0 = 3'b010 when crc_ok_rx, else 3'b101.
REQ-030 WR_BUSY: BUSY_CYCLES cycles with DAT_oe_o=1 and DAT_dat_o=4'hE.
REQ-031 WR_REL: 1 cycle with DAT_oe_o=1 and DAT_dat_o=4'hF, then IDLE; done pulses in that first IDLE cycle and crc_ok=crc_ok_rx.
REQ-032 TX_NAC: 2 cycles with DAT_oe_o=0.
REQ-033 TX_DAT is 1+BLOCK_NIBBLES+16+1 cycles with DAT_oe_o=1, in this order:
- start nibble 4'h0;
- data nibbles;
- 16 CRC nibbles;
- end nibble 4'hF.
REQ-034 tx_rd pulses during the start-bit cycle and during the 8th nibble of each word except the last word, so that tx_data is latched for the following word.
REQ-035 Total tx_rd pulses per block = BLOCK_NIBBLES/8.
REQ-036 After the end nibble, TX_DAT returns to IDLE with DAT_oe_o=0; done pulses and crc_ok=1.
REQ-037 start_rx or start_tx outside IDLE is ignored.
REQ-038 abort in any state: next state IDLE, DAT_oe_o=0, no done, no further rx_we or tx_rd, crc_ok=0.
REQ-039 An all-zero data block produces CRC 16'h0000 on every line.
REQ-040 Counters shall not wrap: the nibble counter is sized for BLOCK_NIBBLES+18 and is cleared in IDLE.

Reset
REQ-041 When rst==0 at a clock edge, next state IDLE with DAT_oe_o=0, DAT_dat_o=4'hF, rx_we=0, tx_rd=0, done=0, busy=0, crc_ok=0 and rx_data=0, and CRCs cleared.
REQ-042 Reset asserted mid-transfer is treated identically to REQ-041; the aborted transfer produces no done.

Verification
REQ-043 BLOCK_NIBBLES=16, host write of all-zero data with CRC 0 and end 4'hF -> 2 rx_we with rx_data=0; after 2 gap cycles DAT0 token 0,0,1,0,1; then BUSY_CYCLES cycles of 4'hE, one cycle of 4'hF, done=1, crc_ok=1.
REQ-044 Same write with one CRC bit flipped on DAT2 -> token 0,1,0,1,1; done with crc_ok=0.
REQ-045 BLOCK_NIBBLES=16, start_tx with tx_data=32'h87654321 then 32'hFEDCBA98 -> after 2 cycles with oe=0: 4'h0, then 1,2,...,8, 8,9,A,...,F, then 16 CRC nibbles matching the reference model, then 4'hF; exactly 2 tx_rd pulses; done.
REQ-046 start_rx and start_tx asserted in the same cycle -> RX_WAIT entered; DAT_oe_o stays 0.
REQ-047 abort during RX_DAT, and separately rst=0 during TX_DAT -> DAT_oe_o=0 next cycle, no done, busy=0; a subsequent full write completes normally.
